// File: rtl/axi_params_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axi_params_pkg
// Description : Bus-level parameters shared by the AXI-facing register logic.
//               A_DATA_WIDTH is the width of one mem-map word.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_params_pkg;

   localparam int unsigned A_DATA_WIDTH = 32;

endpackage : axi_params_pkg
`default_nettype wire

// File: rtl/mem_layout_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_layout_pkg
// Description : Mem-map layout shared between the PL writers and the PS-side
//               register map: index width, block IDs, and the helpers and
//               state type used by the wide-register (bigreg) writer.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_layout_pkg;

   // Width of a mem-map index.
   localparam int unsigned MEM_WIDTH         = 8;

   // Timestamp buffer block: BUFF_SAMPLES data words followed by a valid flag.
   localparam int unsigned BUFF_TIME_BASE_ID = 29;
   localparam int unsigned BUFF_SAMPLES      = 2;

   // Wide-register writer FSM states.
   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WRITE_WORD  = 2'd1,
      WRITE_VALID = 2'd2,
      WAIT_PS     = 2'd3
   } bigreg_state_t;

   // Mem-map index of word 'idx' in a block that starts at 'base'.
   function automatic logic [MEM_WIDTH-1:0] bigreg_word_id(input int unsigned base,
                                                          input int unsigned idx);
      return MEM_WIDTH'(base + idx);
   endfunction

endpackage : mem_layout_pkg
`default_nettype wire

// File: rtl/rtl_bigreg_writer.sv
`default_nettype none
// ============================================================================
// Module      : rtl_bigreg_writer
// Description : Splits a wide value into NUM_WORDS mem-map words, writes them
//               to BASE_ID..BASE_ID+NUM_WORDS-1 (word 0 = LS slice), then
//               writes 1 to VALID_ID and waits for the PS to read it back.
// Revision    : 1.0 - initial release
//
// Ports
//   clk            in   single clock, rising edge
//   rst_n          in   synchronous active-low reset
//   data_in        in   NUM_WORDS*A_DATA_WIDTH value to publish
//   data_valid_in  in   value handshake: valid
//   data_ready_out out  value handshake: ready
//   mem_wr_id      out  mem-map index being written
//   mem_wr_data    out  write data
//   mem_wr_en      out  write request, held until mem_wr_ack
//   mem_wr_ack     in   write accepted (completes when en & ack)
//   ps_ack         in   pulse when the PS has read VALID_ID
//   busy           out  high in every state except IDLE
//   overwrite_cnt  out  unread values replaced (saturating)
//
// Configuration
//   RTL_BIGREG_OVERWRITE_EN : when defined, a new value may be accepted while
//                             waiting for the PS; it replaces the unread one
//                             and bumps overwrite_cnt. When undefined the
//                             writer blocks until ps_ack and the counter is 0.
// ============================================================================
module rtl_bigreg_writer
   import mem_layout_pkg::*;
   import axi_params_pkg::*;
#(
   parameter int unsigned BASE_ID   = BUFF_TIME_BASE_ID,
   parameter int unsigned NUM_WORDS = BUFF_SAMPLES        // 1..16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_WORDS*A_DATA_WIDTH-1:0] data_in,
   input  logic                              data_valid_in,
   output logic                              data_ready_out,
   output logic [MEM_WIDTH-1:0]              mem_wr_id,
   output logic [A_DATA_WIDTH-1:0]           mem_wr_data,
   output logic                              mem_wr_en,
   input  logic                              mem_wr_ack,
   input  logic                              ps_ack,
   output logic                              busy,
   output logic [15:0]                       overwrite_cnt
);

   localparam int unsigned      VALID_ID = BASE_ID + NUM_WORDS;
   localparam int unsigned      IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   bigreg_state_t                          state;
   logic [IDX_W-1:0]                       idx;
   logic [NUM_WORDS-1:0][A_DATA_WIDTH-1:0] latched;
   logic [IDX_W-1:0]                       next_idx;
   logic                                   accept;

   assign next_idx = idx + IDX_W'(1);

   // data_ready_out is only ever high in IDLE, or in WAIT_PS when overwrite
   // is enabled, so this is the single place a new value can enter.
   assign accept   = data_valid_in & data_ready_out;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         idx            <= '0;
         latched        <= '0;
         mem_wr_en      <= 1'b0;
         mem_wr_id      <= '0;
         mem_wr_data    <= '0;
         data_ready_out <= 1'b1;
         busy           <= 1'b0;
`ifdef RTL_BIGREG_OVERWRITE_EN
         overwrite_cnt  <= '0;
`endif
      end else if (accept) begin
         // Word 0 goes out straight from data_in so it is on the bus the
         // cycle after acceptance.
         state          <= WRITE_WORD;
         idx            <= '0;
         latched        <= data_in;
         mem_wr_en      <= 1'b1;
         mem_wr_id      <= bigreg_word_id(BASE_ID, 0);
         mem_wr_data    <= data_in[A_DATA_WIDTH-1:0];
         data_ready_out <= 1'b0;
         busy           <= 1'b1;
`ifdef RTL_BIGREG_OVERWRITE_EN
         // A coincident ps_ack means the old value was read: no overwrite.
         if (state == WAIT_PS && !ps_ack && overwrite_cnt != 16'hFFFF) begin
            overwrite_cnt <= overwrite_cnt + 16'd1;
         end
`endif
      end else begin
         unique case (state)
            IDLE: begin
               // Waiting for a value; outputs already parked.
            end

            WRITE_WORD: begin
               // Without ack the id/data/en registers simply hold.
               if (mem_wr_ack) begin
                  if (idx == LAST_IDX) begin
                     state       <= WRITE_VALID;
                     mem_wr_id   <= MEM_WIDTH'(VALID_ID);
                     mem_wr_data <= A_DATA_WIDTH'(1);
                  end else begin
                     idx         <= next_idx;
                     mem_wr_id   <= bigreg_word_id(BASE_ID, 32'(next_idx));
                     mem_wr_data <= latched[next_idx];
                  end
               end
            end

            WRITE_VALID: begin
               if (mem_wr_ack) begin
                  state       <= WAIT_PS;
                  mem_wr_en   <= 1'b0;
                  mem_wr_id   <= '0;
                  mem_wr_data <= '0;
`ifdef RTL_BIGREG_OVERWRITE_EN
                  data_ready_out <= 1'b1;
`endif
               end
            end

            WAIT_PS: begin
               if (ps_ack) begin
                  state          <= IDLE;
                  data_ready_out <= 1'b1;
                  busy           <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifndef RTL_BIGREG_OVERWRITE_EN
   assign overwrite_cnt = 16'd0;
`endif

endmodule : rtl_bigreg_writer
`default_nettype wire
